// File: rtl/tt_div_pkg.sv
// Shared constants and types for the sequential 8-bit divider.
// Optional zero-divisor shortcut is selected by SEQ_DIV_ZERO_DETECT_EN.
package tt_div_pkg;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int unsigned LOAD_A_BIT = 0;
   localparam int unsigned LOAD_B_BIT = 1;
   localparam int unsigned START_BIT  = 2;
   localparam int unsigned SEL_BIT    = 3;
   localparam int unsigned DBZ_BIT    = 5;
   localparam int unsigned DONE_BIT   = 6;
   localparam int unsigned BUSY_BIT   = 7;

   localparam logic [7:0] UIO_OE_MASK = 8'b1110_0000;

endpackage

// File: rtl/seq_div_core.sv
// Restoring divider core: FSM, iteration counter and datapath, one quotient bit per cycle.
// With SEQ_DIV_ZERO_DETECT_EN a zero divisor short-circuits to DONE after one cycle.
module seq_div_core
   import tt_div_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] quo,
   output logic [WIDTH-1:0] rem,
   output logic             busy,
   output logic             done,
   output logic             dbz
);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] dvd, dvs;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] diff, rem_nxt;
   logic             fits, zero_hit, launch;

   // Shift the next dividend bit into the partial remainder and try to subtract.
   always_comb begin
      trial   = {rem, dvd[WIDTH-1]};
      fits    = trial >= {1'b0, dvs};
      diff    = trial[WIDTH-1:0] - dvs;
      rem_nxt = fits ? diff : trial[WIDTH-1:0];
`ifdef SEQ_DIV_ZERO_DETECT_EN
      zero_hit = (dvs == '0);
`else
      zero_hit = 1'b0;
`endif
   end

   assign launch = (state != S_RUN) && start;
   assign busy   = (state == S_RUN);
   assign done   = (state == S_DONE);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: if (start) state_nxt = S_RUN;
         S_RUN: if (zero_hit || cnt == CNT_W'(WIDTH - 1)) state_nxt = S_DONE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else if (ena) state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dvd <= '0;
         dvs <= '0;
         quo <= '0;
         rem <= '0;
         cnt <= '0;
      end else if (ena) begin
         if (launch) begin
            dvd <= a;
            dvs <= b;
            quo <= '0;
            rem <= '0;
            cnt <= '0;
         end else if (state == S_RUN) begin
            if (zero_hit) begin
               quo <= '1;
               rem <= dvd;
            end else begin
               dvd <= dvd << 1;
               quo <= {quo[WIDTH-2:0], fits};
               rem <= rem_nxt;
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

`ifdef SEQ_DIV_ZERO_DETECT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) dbz <= 1'b0;
      else if (ena) begin
         if (launch) dbz <= 1'b0;
         else if (busy && zero_hit) dbz <= 1'b1;
      end
   end
`else
   assign dbz = 1'b0;
`endif

endmodule

// File: rtl/tt_um_seq_divider.sv
// Tiny Tapeout wrapper: operand/start registers, pin mapping and result mux around seq_div_core.
// SEQ_DIV_ZERO_DETECT_EN enables the zero-divisor shortcut and the div_by_zero flag.
module tt_um_seq_divider
   import tt_div_pkg::*;
(
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   input  logic       ena,
   input  logic       clk,
   input  logic       rst_n
);

   logic [WIDTH-1:0] op_a, op_b, quo, rem;
   logic             start_q, start_edge, load_ok;
   logic             busy, done, dbz;
   logic             unused_uio;

   assign start_edge = uio_in[START_BIT] & ~start_q;
   // A start edge takes priority over a coincident load, and RUN locks the operands.
   assign load_ok    = ~busy & ~start_edge;
   assign unused_uio = &{1'b0, uio_in[7:4]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_a    <= '0;
         op_b    <= '0;
         start_q <= 1'b0;
      end else if (ena) begin
         start_q <= uio_in[START_BIT];
         if (load_ok && uio_in[LOAD_A_BIT]) op_a <= ui_in;
         if (load_ok && uio_in[LOAD_B_BIT]) op_b <= ui_in;
      end
   end

   seq_div_core u_core (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .start (start_edge),
      .a     (op_a),
      .b     (op_b),
      .quo   (quo),
      .rem   (rem),
      .busy  (busy),
      .done  (done),
      .dbz   (dbz)
   );

   assign uo_out = uio_in[SEL_BIT] ? rem : quo;
   assign uio_oe = UIO_OE_MASK;

   always_comb begin
      uio_out           = '0;
      uio_out[BUSY_BIT] = busy;
      uio_out[DONE_BIT] = done;
      uio_out[DBZ_BIT]  = dbz;
   end

endmodule

// File: tb/tb_tt_um_seq_divider.sv
// Scoreboard bench for tt_um_seq_divider: directed divisions, expected results queued at issue.
// Honours SEQ_DIV_ZERO_DETECT_EN for the zero-divisor case.
module tb_tt_um_seq_divider;

   logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;
   logic       ena, clk, rst_n;

   tt_um_seq_divider dut (
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe),
      .ena     (ena),
      .clk     (clk),
      .rst_n   (rst_n)
   );

   typedef struct {
      int         n;
      int         lat;
      logic [7:0] q;
      logic [7:0] r;
      logic       dbz;
   } exp_t;

   exp_t sbq[$];
   exp_t cur;
   bit   have_cur = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   logic probe = 0;
   logic done_prev = 0;

   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int expv);
      n_cmp++;
      if (act != expv) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Monitor: samples 1 time unit after each rising edge.
   always @(posedge clk) begin
      #1;
      if (uio_out[6] && !done_prev) begin
         if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
         end else begin
            cur = sbq.pop_front();
            have_cur = 1;
            chk("done_latency", cyc - cur.n, cur.lat);
            chk("quotient", int'(uo_out), int'(cur.q));
            chk("div_by_zero", int'(uio_out[5]), int'(cur.dbz));
            chk("busy_in_done", int'(uio_out[7]), 0);
         end
      end
      if (probe) begin
         if (have_cur) begin
            chk("remainder", int'(uo_out), int'(cur.r));
            have_cur = 0;
         end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL remainder_probe: got no completed result expected one (cycle %0d)", cyc);
         end
      end
      done_prev = uio_out[6];
   end

   task automatic load_ops(input logic [7:0] a, input logic [7:0] b);
      @(negedge clk); ui_in = a; uio_in = 8'b0000_0001;
      @(negedge clk); ui_in = b; uio_in = 8'b0000_0010;
      @(negedge clk); uio_in = 8'b0000_0000;
   endtask

   task automatic issue_start(input int lat, input logic [7:0] q, input logic [7:0] r,
                              input logic dbz, input bit expect_done);
      exp_t e;
      @(negedge clk);
      if (expect_done) begin
         e.n = cyc + 1; e.lat = lat; e.q = q; e.r = r; e.dbz = dbz;
         sbq.push_back(e);
      end
      uio_in = 8'b0000_0100;
      @(negedge clk);
      uio_in = 8'b0000_0000;
      chk("busy_after_start", int'(uio_out[7]), 1);
   endtask

   task automatic wait_done_and_probe();
      bit seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (uio_out[6]) begin
            seen = 1;
            break;
         end
         @(negedge clk);
      end
      if (!seen) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: got done=0 expected done=1 within 40 cycles");
      end
      @(negedge clk); uio_in = 8'b0000_1000; probe = 1;
      @(negedge clk); uio_in = 8'b0000_0000; probe = 0;
      @(negedge clk);
   endtask

   task automatic run_div(input logic [7:0] a, input logic [7:0] b, input int lat,
                          input logic [7:0] q, input logic [7:0] r, input logic dbz,
                          input bit freeze);
      load_ops(a, b);
      issue_start(lat, q, r, dbz, 1);
      if (freeze) begin
         repeat (2) @(negedge clk);
         ena = 0;
         repeat (3) @(negedge clk);
         ena = 1;
      end
      wait_done_and_probe();
   endtask

   initial begin
      ui_in = 0; uio_in = 0; ena = 1; rst_n = 0;
      repeat (3) @(negedge clk);
      chk("reset_uo_out", int'(uo_out), 0);
      chk("reset_uio_out", int'(uio_out), 0);
      chk("uio_oe", int'(uio_oe), 8'hE0);
      rst_n = 1;
      @(negedge clk);

      run_div(8'd100, 8'd7, 8, 8'd14, 8'd2, 1'b0, 0);
      run_div(8'd255, 8'd1, 8, 8'd255, 8'd0, 1'b0, 0);
      run_div(8'd5, 8'd9, 8, 8'd0, 8'd5, 1'b0, 0);
`ifdef SEQ_DIV_ZERO_DETECT_EN
      run_div(8'd77, 8'd0, 1, 8'hFF, 8'd77, 1'b1, 0);
`else
      run_div(8'd77, 8'd0, 8, 8'hFF, 8'd77, 1'b0, 0);
`endif

      // Load and start during RUN are ignored; a second start reuses the unchanged operands.
      load_ops(8'd200, 8'd3);
      issue_start(8, 8'd66, 8'd2, 1'b0, 1);
      @(negedge clk);
      @(negedge clk);
      ui_in = 8'd9; uio_in = 8'b0000_0101;
      @(negedge clk);
      uio_in = 8'b0000_0000;
      wait_done_and_probe();
      issue_start(8, 8'd66, 8'd2, 1'b0, 1);
      wait_done_and_probe();

      // Reset at edge N+4 aborts the run: no done may follow.
      load_ops(8'd200, 8'd3);
      issue_start(8, 8'd0, 8'd0, 1'b0, 0);
      repeat (3) @(negedge clk);
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      chk("abort_uo_out", int'(uo_out), 0);
      chk("abort_uio_out", int'(uio_out), 0);
      uio_in = 8'b0000_1000;
      #1 chk("abort_remainder", int'(uo_out), 0);
      @(negedge clk);
      uio_in = 8'b0000_0000;
      repeat (12) @(negedge clk);
      have_cur = 0;

      run_div(8'd50, 8'd5, 8, 8'd10, 8'd0, 1'b0, 0);
      run_div(8'd123, 8'd10, 11, 8'd12, 8'd3, 1'b0, 1);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
